// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps up to 2 imem requests in flight,
// buffers returned words in a 2-entry queue and presents the head to IF/ID.
// Redirects flush the queue and discard responses still owed to the old path.
// Optional feature macro: FETCH_MISALIGN_FAULT_EN (misaligned redirect raises
// fetch_fault and halts fetch instead of silently masking the low PC bits).
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           INSTR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction_if,
  output logic [ADDR_WIDTH-1:0]  pc_if,
  output logic                   valid_if,
  output logic                   fetch_fault
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [ADDR_WIDTH-1:0]  r_fetch_pc;
  logic [CNT_W-1:0]       r_out_cnt;
  logic [CNT_W-1:0]       r_q_cnt;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic [ADDR_WIDTH-1:0]  r_pf [2];
  logic [INSTR_WIDTH-1:0] r_q_ins [2];
  logic [ADDR_WIDTH-1:0]  r_q_pc [2];

  logic [ADDR_WIDTH-1:0]  w_fetch_pc_nxt;
  logic [CNT_W-1:0]       w_out_nxt;
  logic [CNT_W-1:0]       w_q_cnt_nxt;
  logic [CNT_W-1:0]       w_drop_nxt;
  logic [ADDR_WIDTH-1:0]  w_pf_nxt [2];
  logic [INSTR_WIDTH-1:0] w_q_ins_nxt [2];
  logic [ADDR_WIDTH-1:0]  w_q_pc_nxt [2];

  logic [SUM_W-1:0]       w_inflight;
  logic                   w_accept;
  logic                   w_rsp;
  logic                   w_keep;
  logic                   w_pop;
  logic                   w_fault;
  logic [ADDR_WIDTH-1:0]  w_fault_pc;

`ifdef FETCH_MISALIGN_FAULT_EN
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_fault_pc;

  // Fault latches on any redirect with nonzero low bits; an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (redirect) begin
      r_fault    <= (redirect_pc[1:0] != 2'b00);
      r_fault_pc <= redirect_pc;
    end
  end

  assign w_fault    = r_fault;
  assign w_fault_pc = r_fault_pc;
`else
  assign w_fault    = 1'b0;
  assign w_fault_pc = '0;
`endif

  // Credit: a request may issue only while in-flight plus buffered words < 2.
  assign w_inflight = SUM_W'(r_out_cnt) + SUM_W'(r_q_cnt);
  assign imem_req   = ~rst & ~w_fault & (w_inflight < SUM_W'(2));
  assign imem_addr  = r_fetch_pc;
  assign w_accept   = imem_req & imem_ready;
  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign w_rsp      = imem_rvalid & (r_out_cnt != '0);
  assign w_keep     = w_rsp & (r_drop_cnt == '0) & ~redirect;

  // Queue head is presented directly; empty queue gives an all-zero bubble.
  assign valid_if       = (r_q_cnt != '0) & ~w_fault;
  assign instruction_if = valid_if ? r_q_ins[0] : '0;
  assign pc_if          = w_fault ? w_fault_pc : (valid_if ? r_q_pc[0] : '0);
  assign fetch_fault    = w_fault;
  assign w_pop          = valid_if & ~stall;

  // Next-state for PC, in-flight PC FIFO, instruction queue and drop counter.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_out_nxt      = r_out_cnt + CNT_W'(w_accept) - CNT_W'(w_rsp);
    w_q_cnt_nxt    = r_q_cnt;
    w_drop_nxt     = r_drop_cnt;
    w_pf_nxt       = r_pf;
    w_q_ins_nxt    = r_q_ins;
    w_q_pc_nxt     = r_q_pc;

    if (w_accept) w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(4);

    if (w_rsp) w_pf_nxt[0] = r_pf[1];
    if (w_accept) w_pf_nxt[1'(r_out_cnt - CNT_W'(w_rsp))] = r_fetch_pc;

    if (w_pop) begin
      w_q_ins_nxt[0] = r_q_ins[1];
      w_q_pc_nxt[0]  = r_q_pc[1];
      w_q_cnt_nxt    = r_q_cnt - CNT_W'(1);
    end
    if (w_keep) begin
      w_q_ins_nxt[1'(r_q_cnt - CNT_W'(w_pop))] = imem_rdata;
      w_q_pc_nxt[1'(r_q_cnt - CNT_W'(w_pop))]  = r_pf[0];
      w_q_cnt_nxt = w_q_cnt_nxt + CNT_W'(1);
    end

    if (w_rsp && (r_drop_cnt != '0)) w_drop_nxt = r_drop_cnt - CNT_W'(1);

    // Redirect: everything still owed by memory after this cycle is wrong-path.
    if (redirect) begin
      w_q_cnt_nxt    = '0;
      w_drop_nxt     = w_out_nxt;
      w_fetch_pc_nxt = redirect_pc & ~ADDR_WIDTH'(3);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_VECTOR;
      r_out_cnt  <= '0;
      r_q_cnt    <= '0;
      r_drop_cnt <= '0;
      r_pf       <= '{default: '0};
      r_q_ins    <= '{default: '0};
      r_q_pc     <= '{default: '0};
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_out_cnt  <= w_out_nxt;
      r_q_cnt    <= w_q_cnt_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_pf       <= w_pf_nxt;
      r_q_ins    <= w_q_ins_nxt;
      r_q_pc     <= w_q_pc_nxt;
    end
  end

endmodule
